// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared state encoding, sync byte and PID constants for the USB receive path
package usb_rx_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_EOP_WAIT, ST_DONE, ST_ERR, ST_ERR_IDLE
  } state_t;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_STALL = 4'b1110;
  function automatic logic pid_ok(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction
endpackage

// File: rtl/rx_bit_counter.sv
// rx_bit_counter: 3-bit bit position counter, wrap flags the eighth bit of a byte
module rx_bit_counter (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       enable,
  output logic [2:0] count,
  output logic       wrap
);
  assign wrap = enable && count == 3'd7;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= count + 3'd1;
endmodule

// File: rtl/rx_control_unit.sv
// rx_control_unit: USB packet receive FSM driving the RX FIFO write strobe and status flags
module rx_control_unit
  import usb_rx_pkg::*;
#(
  parameter int MAX_DATA_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       shift_enable,
  input  logic       eop,
  input  logic [7:0] rx_packet_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic [3:0] rx_pid,
  output logic       rx_data_ready,
  output logic [6:0] byte_count
);
  state_t state, state_nx;
  logic [2:0] bit_cnt;
  logic wrap, byte_done, start, pid_valid, is_data, at_max;
  assign start = (state == ST_IDLE || state == ST_ERR_IDLE) && d_edge;
  rx_bit_counter u_bit_counter (
    .clk(clk), .n_rst(n_rst), .clear(start), .enable(shift_enable), .count(bit_cnt), .wrap(wrap)
  );
  assign pid_valid = pid_ok(rx_packet_data);
  assign is_data = rx_packet_data[3:0] == PID_DATA0 || rx_packet_data[3:0] == PID_DATA1;
  assign at_max = byte_count == 7'(MAX_DATA_BYTES);
  // eop is checked before byte_done everywhere so a coinciding byte is dropped
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     state_nx = d_edge ? ST_SYNC : ST_IDLE;
      ST_SYNC:     state_nx = eop ? ST_ERR : !byte_done ? ST_SYNC :
                              rx_packet_data == SYNC_BYTE ? ST_PID : ST_ERR;
      ST_PID:      state_nx = eop ? ST_ERR : !byte_done ? ST_PID :
                              !pid_valid ? ST_ERR : is_data ? ST_DATA : ST_EOP_WAIT;
      ST_DATA:     state_nx = eop ? (bit_cnt == 3'd0 ? ST_DONE : ST_ERR) :
                              byte_done && at_max ? ST_ERR : ST_DATA;
      ST_EOP_WAIT: state_nx = eop ? (bit_cnt == 3'd0 ? ST_DONE : ST_ERR) :
                              byte_done ? ST_ERR : ST_EOP_WAIT;
      ST_DONE:     state_nx = ST_IDLE;
      ST_ERR:      state_nx = eop ? ST_ERR_IDLE : ST_ERR;
      ST_ERR_IDLE: state_nx = d_edge ? ST_SYNC : ST_ERR_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end
  assign w_enable = state == ST_DATA && byte_done && !eop && !at_max;
  assign rcving = state inside {ST_SYNC, ST_PID, ST_DATA, ST_EOP_WAIT, ST_ERR};
  assign r_error = state inside {ST_ERR, ST_ERR_IDLE};
  assign rx_data_ready = state == ST_DONE;
  // byte_done trails the wrapping strobe so the shift register output is already settled
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state      <= ST_IDLE;
      byte_done  <= 1'b0;
      rx_pid     <= 4'h0;
      byte_count <= '0;
    end else begin
      state     <= state_nx;
      byte_done <= wrap && !start;
      if (start) byte_count <= '0;
      else if (w_enable) byte_count <= byte_count + 7'd1;
      if (state == ST_PID && byte_done && !eop && pid_valid) rx_pid <= rx_packet_data[3:0];
    end
endmodule

// File: doc/rx_control_unit.md
RX_CONTROL_UNIT -- requirements
Module: rx_control_unit

Interface
REQ-001 SHALL have parameter MAX_DATA_BYTES, default 64, maximum bytes accepted in one DATA packet, CRC bytes included.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port n_rst  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port d_edge  in  1  decoded line transition seen; marks packet start.
REQ-005 SHALL have port shift_enable  in  1  one-cycle strobe per received bit, also driving the 24-bit receive shift register.
REQ-006 SHALL have port eop  in  1  end-of-packet detected on the bus.
REQ-007 SHALL have port rx_packet_data  in  8  most recent byte from the shift register.
REQ-008 SHALL have port rcving  out  1  packet reception in progress.
REQ-009 SHALL have port w_enable  out  1  one-cycle RX FIFO write strobe.
REQ-010 SHALL have port r_error  out  1  sticky receive-error flag.
REQ-011 SHALL have port rx_pid  out  4  PID of the last valid packet.
REQ-012 SHALL have port rx_data_ready  out  1  one-cycle pulse on error-free packet completion.
REQ-013 SHALL have port byte_count  out  7  data bytes written in the current packet.

Function
REQ-014 SHALL hold an internal 3-bit bit counter, cleared on entry to SYNC, incremented on each shift_enable, wrapping 7->0.
REQ-015 SHALL assert internal byte_done one cycle after the shift_enable that wraps the counter, so rx_packet_data is already updated.
REQ-016 SHALL implement states IDLE, SYNC, PID, DATA, EOP_WAIT, DONE, ERR, ERR_IDLE.
REQ-017 IDLE SHALL move to SYNC on d_edge and assert rcving from the following cycle.
REQ-018 In SYNC, byte_done SHALL move to PID if rx_packet_data == SYNC_BYTE (8'h80) and to ERR otherwise.
REQ-019 In PID, byte_done with rx_packet_data[7:4] == ~rx_packet_data[3:4-4] (upper nibble = complement of [3:0]) SHALL latch rx_pid = rx_packet_data[3:0].
REQ-020 On a valid PID, DATA0 (4'b0011) or DATA1 (4'b1011) SHALL move to DATA; every other valid PID SHALL move to EOP_WAIT.
REQ-021 On an invalid PID check, the block SHALL move to ERR and leave rx_pid unchanged.
REQ-022 In DATA, each byte_done SHALL pulse w_enable for exactly one cycle and increment byte_count.
REQ-023 In DATA, byte_done when byte_count == MAX_DATA_BYTES SHALL move to ERR with no write.
REQ-024 eop with bit counter == 0 SHALL move DATA or EOP_WAIT to DONE.
REQ-025 eop with bit counter != 0, or eop in SYNC or PID, SHALL move to ERR.
REQ-026 In EOP_WAIT, byte_done SHALL move to ERR.
REQ-027 DONE SHALL pulse rx_data_ready for one cycle, deassert rcving, and return to IDLE.
REQ-028 ERR SHALL set r_error, keep rcving high, ignore bytes (no w_enable), and on eop move to ERR_IDLE with rcving low.
REQ-029 In ERR_IDLE, d_edge SHALL clear r_error and enter SYNC; r_error SHALL otherwise stay set.
REQ-030 If eop and byte_done coincide, eop SHALL take priority; the byte SHALL NOT be written.
REQ-031 byte_count SHALL clear on entry to SYNC and hold through DONE/ERR until the next packet.

Reset
REQ-032 Reset SHALL force state IDLE, bit counter 0, rcving 0, w_enable 0, r_error 0, rx_pid 4'h0, rx_data_ready 0, byte_count 0, effective immediately regardless of clk.
REQ-033 Reset asserted mid-packet SHALL abandon the packet without asserting w_enable or rx_data_ready.

Structure
REQ-034 Package usb_rx_pkg SHALL hold the state enum, SYNC_BYTE, and the PID constants (ACK, NAK, STALL, DATA0, DATA1, IN, OUT, SETUP).
REQ-035 The bit counter SHALL be sub-module rx_bit_counter (clear, enable, wrap flag); the FSM and byte_count SHALL stay in rx_control_unit.

Verification
REQ-036 d_edge, sync 8'h80, PID 8'hC3, 3 data bytes, eop at bit 0 -> rx_pid=3, three w_enable pulses, byte_count=3, rx_data_ready pulse, r_error=0.
REQ-037 Sync 8'h80, PID 8'hD2 (ACK), eop -> rx_pid=2, no w_enable, rx_data_ready pulse.
REQ-038 Sync byte 8'h81 -> ERR, r_error=1 until next d_edge, no writes, rcving drops after eop.
REQ-039 Valid DATA0, then eop after 4 bits of the second byte -> one write, r_error=1, no rx_data_ready.
REQ-040 MAX_DATA_BYTES=4, 5 data bytes -> four writes, r_error=1 on the fifth byte_done.
REQ-041 n_rst low for 1 cycle mid-DATA -> all outputs at reset values asynchronously; next d_edge packet received cleanly.
